timer_tick_scheduler: RTL and testbench
=======================================

TIMER_TICK_SCHEDULER -- requirements
Module: timer_tick_scheduler

Interface
REQ-001 SHALL have parameter PERIOD, 32 bits, default 32'd49999, the interval-timer period in clk cycles minus one (1 kHz at 50 MHz).
REQ-002 SHALL have parameter DIV_A, 8 bits, default 5, the base ticks per task-A request.
REQ-003 SHALL have parameter DIV_B, 8 bits, default 100, the base ticks per task-B request.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: level request to run the schedule.
REQ-007 SHALL have port avm_address, output, 3 bits: timer register address.
REQ-008 SHALL have ports avm_chipselect (output, 1 bit) and avm_write_n (output, 1 bit, active low).
REQ-009 SHALL have port avm_writedata, output, 16 bits: timer write data.
REQ-010 SHALL have port timer_irq, input, 1 bit: the timer interrupt, level, registered inside the timer.
REQ-011 SHALL have ports tick_base, tick_a and tick_b, outputs, 1 bit each: single-cycle strobes.
REQ-012 SHALL have ports req_a / req_b (outputs, 1 bit each) and ack_a / ack_b (inputs, 1 bit each): per-task request/acknowledge handshake.
REQ-013 SHALL have ports overrun_a / overrun_b (outputs, 1 bit each, sticky) and clr_overrun (input, 1 bit).
REQ-014 SHALL have port running, output, 1 bit: high in RUN and CLR only.

Function
REQ-015 SHALL issue only single-cycle writes: avm_chipselect=1 and avm_write_n=0 for exactly one cycle, with no wait states; it SHALL issue no reads. When idle, the bus outputs SHALL be chipselect=0, write_n=1, address=0, writedata=0.
REQ-016 SHALL implement FSM states IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, STOP.
REQ-017 SHALL move IDLE->WR_PL when enable=1; WR_PL, WR_PH and WR_CTRL SHALL each last one cycle and advance unconditionally; WR_CTRL->RUN.
REQ-018 SHALL write, in order: WR_PL addr 2 data PERIOD[15:0]; WR_PH addr 3 data PERIOD[31:16]; WR_CTRL addr 1 data 16'h0007 (start, continuous, irq enable).
REQ-019 SHALL, in RUN with timer_irq=1, move to CLR; CLR SHALL write addr 0 data 0 (status clear), assert tick_base in the same cycle, and return to RUN.
REQ-020 SHALL, in RUN with enable=0 and timer_irq=0, move to STOP; STOP SHALL write addr 1 data 16'h0008 (stop) and go to IDLE. If timer_irq=1 and enable=0 together, CLR SHALL take priority.
REQ-021 SHALL ignore enable during WR_PL..WR_CTRL; the programming sequence always completes.
REQ-022 SHALL keep divider counter cnt_a in range 0..DIV_A-1, incremented on tick_base; on a wrap (cnt_a=DIV_A-1 with tick_base) it SHALL reset to 0 and pulse tick_a in the same cycle as tick_base. Task B SHALL behave identically with cnt_b and DIV_B.
REQ-023 SHALL set req_a on tick_a and clear it on ack_a. When tick_a and ack_a coincide, req_a SHALL remain 1 and no overrun SHALL be flagged. Task B identical.
REQ-024 SHALL set overrun_a when tick_a occurs with req_a=1 and ack_a=0; overrun_a SHALL clear only on clr_overrun, and a set in the same cycle SHALL win over the clear. Task B identical.
REQ-025 SHALL clear divider counters on entry to STOP and SHALL hold req_x and overrun_x across STOP/IDLE.
REQ-026 SHALL accept only DIV_A, DIV_B >= 1; with DIV=1 every base tick is a task tick.

Reset
REQ-027 SHALL, on reset_n=0 at any time including mid-sequence: FSM=IDLE, all counters 0, every 1-bit output 0 except avm_write_n=1, avm_address=0, avm_writedata=0.
REQ-028 SHALL, after reset release with enable=1, restart from WR_PL at the next clock.

Structure
REQ-029 SHALL place the state enum, timer register address constants (STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3) and control-bit constants (ITO=0, CONT=1, START=2, STOP=3) in package timer_sched_pkg.
REQ-030 SHALL implement the counter+request+overrun logic as one sub-module, tick_divider, instantiated twice.

Verification
REQ-031 Scenario: reset, enable=1 -> three consecutive writes (2,16'hC34F), (3,16'h0000), (1,16'h0007), then running=1.
REQ-032 Scenario: in RUN, pulse timer_irq until cleared -> one-cycle write (0,0) with tick_base=1 in the same cycle; after 5 such ticks, tick_a=1 coincident with the 5th.
REQ-033 Scenario: no ack_a across 10 base ticks -> overrun_a=1 at the 10th; clr_overrun -> 0; clr_overrun together with the next overflow -> overrun_a stays 1.
REQ-034 Scenario: ack_a asserted in the same cycle as tick_a -> req_a stays 1, overrun_a stays 0.
REQ-035 Scenario: enable=0 during WR_PH -> WR_CTRL still written, then STOP write (1,16'h0008), then IDLE with running=0.
REQ-036 Scenario: reset_n asserted in CLR -> all outputs at reset values immediately; timer_irq=1 with enable=1 after release -> full programming sequence precedes any CLR.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared types and timer register map for the timer tick scheduler.
// The control words are built from the control bit positions.
package timer_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_PL   = 3'd1,
    S_WR_PH   = 3'd2,
    S_WR_CTRL = 3'd3,
    S_RUN     = 3'd4,
    S_CLR     = 3'd5,
    S_STOP    = 3'd6
  } state_e;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  function automatic logic [15:0] ctrl_bit(input int pos);
    ctrl_bit = 16'h0001 << pos;
  endfunction

  localparam logic [15:0] CTRL_GO_WORD   = ctrl_bit(CTRL_START) | ctrl_bit(CTRL_CONT) | ctrl_bit(CTRL_ITO);
  localparam logic [15:0] CTRL_HALT_WORD = ctrl_bit(CTRL_STOP);

endpackage

// File: rtl/tick_divider.sv
// Divides base ticks into task ticks and runs the request/ack/overrun
// bookkeeping for one scheduled task. DIV must be at least 1.
module tick_divider #(
  parameter logic [7:0] DIV = 8'd5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic clear,
  input  logic ack,
  input  logic clr_overrun,
  output logic task_tick,
  output logic req,
  output logic overrun
);

  logic [7:0] cnt;
  logic       wrap;

  assign wrap      = (cnt == DIV - 8'd1);
  assign task_tick = tick & wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= 8'd0;
      req     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clear)
        cnt <= 8'd0;
      else if (tick)
        cnt <= wrap ? 8'd0 : cnt + 8'd1;

      // A new task tick outranks a simultaneous ack, so the request stays up.
      if (task_tick)
        req <= 1'b1;
      else if (ack)
        req <= 1'b0;

      if (task_tick && req && !ack)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_tick_scheduler.sv
// Programs an interval timer over a write-only bus, turns its interrupts
// into base ticks and divides those into two task request streams.
module timer_tick_scheduler
  import timer_sched_pkg::*;
#(
  parameter logic [31:0] PERIOD = 32'd49999,
  parameter logic [7:0]  DIV_A  = 8'd5,
  parameter logic [7:0]  DIV_B  = 8'd100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic        timer_irq,
  output logic        tick_base,
  output logic        tick_a,
  output logic        tick_b,
  output logic        req_a,
  output logic        req_b,
  input  logic        ack_a,
  input  logic        ack_b,
  output logic        overrun_a,
  output logic        overrun_b,
  input  logic        clr_overrun,
  output logic        running
);

  state_e state, state_nxt;
  logic   stop_entry;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (enable) state_nxt = S_WR_PL;
      S_WR_PL:   state_nxt = S_WR_PH;
      S_WR_PH:   state_nxt = S_WR_CTRL;
      S_WR_CTRL: state_nxt = S_RUN;
      S_RUN: begin
        if (timer_irq)    state_nxt = S_CLR;
        else if (!enable) state_nxt = S_STOP;
      end
      S_CLR:     state_nxt = S_RUN;
      S_STOP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs decode straight from the registered state: one write per
  // single-cycle state, no wait states.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 3'd0;
    avm_writedata  = 16'h0000;
    case (state)
      S_WR_PL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_PERIODL;
        avm_writedata  = PERIOD[15:0];
      end
      S_WR_PH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_PERIODH;
        avm_writedata  = PERIOD[31:16];
      end
      S_WR_CTRL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_CONTROL;
        avm_writedata  = CTRL_GO_WORD;
      end
      S_CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_STATUS;
        avm_writedata  = 16'h0000;
      end
      S_STOP: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_CONTROL;
        avm_writedata  = CTRL_HALT_WORD;
      end
      default: ;
    endcase
  end

  assign tick_base  = (state == S_CLR);
  assign running    = (state == S_RUN) || (state == S_CLR);
  assign stop_entry = (state == S_RUN) && (state_nxt == S_STOP);

  tick_divider #(.DIV(DIV_A)) u_div_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick_base),
    .clear       (stop_entry),
    .ack         (ack_a),
    .clr_overrun (clr_overrun),
    .task_tick   (tick_a),
    .req         (req_a),
    .overrun     (overrun_a)
  );

  tick_divider #(.DIV(DIV_B)) u_div_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick_base),
    .clear       (stop_entry),
    .ack         (ack_b),
    .clr_overrun (clr_overrun),
    .task_tick   (tick_b),
    .req         (req_b),
    .overrun     (overrun_b)
  );

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed bench for timer_tick_scheduler: programming, base/task ticks,
// overrun handling, stop, and reset in the middle of a status clear.
module tb_timer_tick_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic        timer_irq;
  logic        tick_base, tick_a, tick_b;
  logic        req_a, req_b;
  logic        ack_a, ack_b;
  logic        overrun_a, overrun_b;
  logic        clr_overrun;
  logic        running;

  int n_cmp = 0;
  int n_err = 0;
  int n_tick = 0;

  always #5 clk = ~clk;

  timer_tick_scheduler #(
    .PERIOD (32'd49999),
    .DIV_A  (8'd5),
    .DIV_B  (8'd3)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .timer_irq      (timer_irq),
    .tick_base      (tick_base),
    .tick_a         (tick_a),
    .tick_b         (tick_b),
    .req_a          (req_a),
    .req_b          (req_b),
    .ack_a          (ack_a),
    .ack_b          (ack_b),
    .overrun_a      (overrun_a),
    .overrun_b      (overrun_b),
    .clr_overrun    (clr_overrun),
    .running        (running)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".cs"},      32'(avm_chipselect), 32'd0);
    check({tag, ".wn"},      32'(avm_write_n),    32'd1);
    check({tag, ".addr"},    32'(avm_address),    32'd0);
    check({tag, ".data"},    32'(avm_writedata),  32'd0);
    check({tag, ".ticks"},   {29'd0, tick_base, tick_a, tick_b}, 32'd0);
    check({tag, ".reqs"},    {30'd0, req_a, req_b}, 32'd0);
    check({tag, ".ovr"},     {30'd0, overrun_a, overrun_b}, 32'd0);
    check({tag, ".running"}, 32'(running), 32'd0);
  endtask

  task automatic expect_write(input string tag, input logic [2:0] addr, input logic [15:0] data);
    check({tag, ".cs"},   32'(avm_chipselect), 32'd1);
    check({tag, ".wn"},   32'(avm_write_n),    32'd0);
    check({tag, ".addr"}, 32'(avm_address),    32'(addr));
    check({tag, ".data"}, 32'(avm_writedata),  32'(data));
  endtask

  // Call at a negedge with the DUT in IDLE (or reset just released) and enable=1.
  task automatic program_seq(input string tag);
    @(negedge clk);
    expect_write({tag, ".pl"}, 3'd2, 16'hC34F);
    check({tag, ".pl.run"}, 32'(running), 32'd0);
    @(negedge clk);
    expect_write({tag, ".ph"}, 3'd3, 16'h0000);
    check({tag, ".ph.tb"}, 32'(tick_base), 32'd0);
    @(negedge clk);
    expect_write({tag, ".ctrl"}, 3'd1, 16'h0007);
    @(negedge clk);
    check({tag, ".run.cs"}, 32'(avm_chipselect), 32'd0);
    check({tag, ".running"}, 32'(running), 32'd1);
  endtask

  // One base tick from RUN: the interrupt is raised, the CLR cycle is checked
  // and the timer drops the interrupt after the status write.
  task automatic base_tick(input logic ack_a_v, input logic ack_b_v, input logic clr_v);
    logic exp_ta, exp_tb;
    string tag;
    n_tick++;
    exp_ta = (n_tick % 5 == 0);
    exp_tb = (n_tick % 3 == 0);
    tag = $sformatf("tick%0d", n_tick);
    timer_irq = 1'b1;
    @(negedge clk);
    expect_write({tag, ".clr"}, 3'd0, 16'h0000);
    check({tag, ".tick_base"}, 32'(tick_base), 32'd1);
    check({tag, ".tick_a"},    32'(tick_a),    32'(exp_ta));
    check({tag, ".tick_b"},    32'(tick_b),    32'(exp_tb));
    timer_irq   = 1'b0;
    ack_a       = ack_a_v;
    ack_b       = ack_b_v;
    clr_overrun = clr_v;
    @(negedge clk);
    ack_a       = 1'b0;
    ack_b       = 1'b0;
    clr_overrun = 1'b0;
    check({tag, ".after.tick_base"}, 32'(tick_base), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; timer_irq = 1'b0;
    ack_a = 1'b0; ack_b = 1'b0; clr_overrun = 1'b0;
    #1;
    check_reset("rst0");
    repeat (2) @(negedge clk);
    check_reset("rst1");
    reset_n = 1'b1;
    enable  = 1'b1;
    program_seq("prog1");

    // Ten ticks with no acks: task A ticks at 5 and 10, task B at 3, 6, 9.
    n_tick = 0;
    for (int i = 0; i < 10; i++) base_tick(1'b0, 1'b0, 1'b0);
    check("t10.req_a",     32'(req_a),     32'd1);
    check("t10.overrun_a", 32'(overrun_a), 32'd1);
    check("t10.overrun_b", 32'(overrun_b), 32'd1);

    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("clr1.overrun_a", 32'(overrun_a), 32'd0);
    check("clr1.overrun_b", 32'(overrun_b), 32'd0);

    // Overrun set coinciding with clr_overrun: set wins.
    for (int i = 0; i < 4; i++) base_tick(1'b0, 1'b0, 1'b0);
    base_tick(1'b0, 1'b0, 1'b1);
    check("t15.overrun_a", 32'(overrun_a), 32'd1);

    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("clr2.overrun_a", 32'(overrun_a), 32'd0);

    // Ack coinciding with tick_a keeps the request and flags no overrun.
    for (int i = 0; i < 4; i++) base_tick(1'b0, 1'b0, 1'b0);
    base_tick(1'b1, 1'b0, 1'b0);
    check("t20.req_a",     32'(req_a),     32'd1);
    check("t20.overrun_a", 32'(overrun_a), 32'd0);

    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    check("ack.req_a", 32'(req_a), 32'd0);

    // Stop from RUN; requests and overruns hold across STOP/IDLE.
    enable = 1'b0;
    @(negedge clk);
    expect_write("stop1", 3'd1, 16'h0008);
    check("stop1.running", 32'(running), 32'd0);
    @(negedge clk);
    check("idle1.cs",        32'(avm_chipselect), 32'd0);
    check("idle1.running",   32'(running),        32'd0);
    check("idle1.req_b",     32'(req_b),          32'd1);
    check("idle1.overrun_b", 32'(overrun_b),      32'd1);

    // Restart: dividers were cleared, so task B must not fire on tick 1.
    enable = 1'b1;
    program_seq("prog2");
    n_tick = 0;
    for (int i = 0; i < 5; i++) base_tick(1'b0, 1'b0, 1'b0);

    enable = 1'b0;
    @(negedge clk);
    expect_write("stop2", 3'd1, 16'h0008);
    @(negedge clk);
    check("idle2.running", 32'(running), 32'd0);

    // enable dropped during WR_PH: programming completes, then STOP.
    enable = 1'b1;
    @(negedge clk);
    expect_write("abort.pl", 3'd2, 16'hC34F);
    enable = 1'b0;
    @(negedge clk);
    expect_write("abort.ph", 3'd3, 16'h0000);
    @(negedge clk);
    expect_write("abort.ctrl", 3'd1, 16'h0007);
    @(negedge clk);
    check("abort.run.running", 32'(running), 32'd1);
    check("abort.run.cs",      32'(avm_chipselect), 32'd0);
    @(negedge clk);
    expect_write("abort.stop", 3'd1, 16'h0008);
    @(negedge clk);
    check("abort.idle.running", 32'(running), 32'd0);
    check("abort.idle.cs",      32'(avm_chipselect), 32'd0);

    // Reset while in CLR, then a pending interrupt must wait for programming.
    enable = 1'b1;
    program_seq("prog3");
    timer_irq = 1'b1;
    @(negedge clk);
    check("pre_rst.tick_base", 32'(tick_base), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset("rst_clr");
    @(negedge clk);
    reset_n = 1'b1;
    program_seq("prog4");
    @(negedge clk);
    expect_write("post_rst.clr", 3'd0, 16'h0000);
    check("post_rst.tick_base", 32'(tick_base), 32'd1);
    timer_irq = 1'b0;
    @(negedge clk);
    check("post_rst.running", 32'(running), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
